// File: rtl/servo_pkg.sv
// Shared constants and width helpers for the multi-channel servo PWM block.
// Both the top level and any reuse of the prescaler import this package.
package servo_pkg;

    localparam int unsigned DEF_CH_COUNT    = 4;
    localparam int unsigned DEF_POS_W       = 8;
    localparam int unsigned DEF_CLK_DIV     = 0;
    localparam int unsigned DEF_FRAME_TICKS = 2560;
    localparam int unsigned DEF_BASE_TICKS  = 256;

    // Channel index width; a single channel still needs a 1-bit select port.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned frame_cnt_w(input int unsigned frame_ticks);
        return (frame_ticks > 1) ? $clog2(frame_ticks) : 1;
    endfunction

    // Pulse-width arithmetic width: BASE_TICKS + position can never overflow it.
    function automatic int unsigned pulse_w(input int unsigned pos_w,
                                            input int unsigned frame_ticks);
        return pos_w + frame_cnt_w(frame_ticks) + 1;
    endfunction

endpackage

// File: rtl/servo_prescaler.sv
// Generic clock-enable divider: tick is high for one clock every CLK_DIV+1 clocks.
// CLK_DIV=0 degenerates to a constant-high tick with no counter.
module servo_prescaler #(
    parameter int unsigned CLK_DIV = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    generate
        if (CLK_DIV == 0) begin : g_bypass
            logic bypass_unused;
            assign bypass_unused = clk ^ rst_n;
            assign tick = 1'b1;
        end else begin : g_div
            localparam int unsigned DW = $clog2(CLK_DIV + 1);

            logic [DW-1:0] cnt_q;
            logic [DW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DW'(CLK_DIV)) begin
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tick = (cnt_q == DW'(CLK_DIV));
        end
    endgenerate

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo pulse generator with shadowed positions applied at frame wrap.
// Define SERVO_STAGGER_EN to spread channel rising edges evenly across the frame.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned CH_COUNT    = DEF_CH_COUNT,
    parameter int unsigned POS_W       = DEF_POS_W,
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int unsigned BASE_TICKS  = DEF_BASE_TICKS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ch_idx_w(CH_COUNT)-1:0] wr_ch,
    input  logic [POS_W-1:0]              wr_pos,
    input  logic [CH_COUNT-1:0]           ch_en,
    output logic [CH_COUNT-1:0]           servo_out,
    output logic                          frame_start
);

    localparam int unsigned CH_W = ch_idx_w(CH_COUNT);
    localparam int unsigned FC_W = frame_cnt_w(FRAME_TICKS);
    localparam int unsigned PW_W = pulse_w(POS_W, FRAME_TICKS);

`ifdef SERVO_STAGGER_EN
    if (BASE_TICKS + (1 << POS_W) - 1 > FRAME_TICKS / CH_COUNT) begin : g_stagger_chk
        $fatal(1, "servo_pwm_multi: longest pulse does not fit in one stagger slot");
    end
`endif

    logic            tick;
    logic            wrap;
    logic [FC_W-1:0] frame_cnt_q;
    logic [FC_W-1:0] frame_cnt_d;
    logic            frame_start_q;

    servo_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wrap = tick && (frame_cnt_q == FC_W'(FRAME_TICKS - 1));

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (wrap) begin
            frame_cnt_d = '0;
        end else if (tick) begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= wrap;
        end
    end

    assign frame_start = frame_start_q;

    generate
        for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
            logic [POS_W-1:0] shadow_q;
            logic [POS_W-1:0] shadow_d;
            logic [POS_W-1:0] active_q;
            logic [POS_W-1:0] active_d;
            logic             en_act_q;
            logic             en_act_d;
            logic             out_q;
            logic             out_d;
            logic [PW_W-1:0]  width;
            logic             in_window;

            // An out-of-range wr_ch matches no channel, so it is dropped here.
            always_comb begin
                shadow_d = shadow_q;
                if (wr_en && (wr_ch == CH_W'(gi))) begin
                    shadow_d = wr_pos;
                end
            end

            // Active copy samples the shadow value from before any same-edge write.
            assign active_d = wrap ? shadow_q : active_q;

            // Dropping ch_en clears en_act so a mid-frame re-enable waits for the wrap.
            assign en_act_d = wrap ? ch_en[gi] : (en_act_q & ch_en[gi]);

            assign width = PW_W'(BASE_TICKS) + PW_W'(active_q);

`ifdef SERVO_STAGGER_EN
            localparam int unsigned OFF = gi * (FRAME_TICKS / CH_COUNT);
            assign in_window = (frame_cnt_q >= FC_W'(OFF)) &&
                               (PW_W'(frame_cnt_q - FC_W'(OFF)) < width);
`else
            assign in_window = (PW_W'(frame_cnt_q) < width);
`endif

            assign out_d = en_act_q & ch_en[gi] & in_window;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q <= '0;
                    active_q <= '0;
                    en_act_q <= 1'b0;
                    out_q    <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                    en_act_q <= en_act_d;
                    out_q    <= out_d;
                end
            end

            assign servo_out[gi] = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: per-frame pulse widths are queued as
// stimulus is applied and compared when each frame_start closes a frame.
module tb_servo_pwm_multi;

    localparam int FRAME = 2560;

    logic       clk = 1'b0;
    bit         clk_run = 1'b1;
    logic       rst_n = 1'b1;

    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_pos = '0;
    logic [3:0] ch_en = '0;
    logic [3:0] servo_out;
    logic       frame_start;

    logic       wr_en3 = 1'b0;
    logic [1:0] wr_ch3 = '0;
    logic [7:0] wr_pos3 = '0;
    logic [2:0] ch_en3 = '0;
    logic [2:0] servo_out3;
    logic       frame_start3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int fid;
        int w  [4];
        int w3 [3];
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;

    int frame_idx = 0;
    int hi_cnt [4];
    int hi3    [3];
    int cyc = 0;
    int last_fs = 0;
    bit armed = 1'b0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    servo_pwm_multi #(
        .CH_COUNT(4), .POS_W(8), .CLK_DIV(0), .FRAME_TICKS(2560), .BASE_TICKS(256)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .servo_out(servo_out), .frame_start(frame_start)
    );

    servo_pwm_multi #(
        .CH_COUNT(3), .POS_W(8), .CLK_DIV(0), .FRAME_TICKS(2560), .BASE_TICKS(256)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_pos(wr_pos3),
        .ch_en(ch_en3), .servo_out(servo_out3), .frame_start(frame_start3)
    );

    // Frame monitor: closes a frame at each frame_start and pops its expectation.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            frame_idx = 0;
            armed = 1'b0;
            cyc = 0;
            for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
            for (int k = 0; k < 3; k++) hi3[k] = 0;
        end else begin
            cyc++;
            if (frame_start) begin
                if (armed) begin
                    checks++;
                    if (cyc - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d expected %0d", cyc - last_fs, FRAME);
                    end
                end
                armed = 1'b1;
                last_fs = cyc;
                checks++;
                if (frame_start3 !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_start3_align: got %0b expected 1", frame_start3);
                end
                while (sb_q.size() > 0 && sb_q[0].fid == frame_idx) begin
                    mon_e = sb_q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        checks++;
                        if (hi_cnt[k] != mon_e.w[k]) begin
                            errors++;
                            $display("FAIL width frame%0d ch%0d: got %0d expected %0d",
                                     frame_idx, k, hi_cnt[k], mon_e.w[k]);
                        end
                    end
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if (hi3[k] != mon_e.w3[k]) begin
                            errors++;
                            $display("FAIL width3 frame%0d ch%0d: got %0d expected %0d",
                                     frame_idx, k, hi3[k], mon_e.w3[k]);
                        end
                    end
                    $display("frame %0d widths %0d %0d %0d %0d | %0d %0d %0d", frame_idx,
                             hi_cnt[0], hi_cnt[1], hi_cnt[2], hi_cnt[3], hi3[0], hi3[1], hi3[2]);
                end
                frame_idx++;
                for (int k = 0; k < 4; k++) hi_cnt[k] = int'(servo_out[k]);
                for (int k = 0; k < 3; k++) hi3[k] = int'(servo_out3[k]);
            end else begin
                for (int k = 0; k < 4; k++) hi_cnt[k] += int'(servo_out[k]);
                for (int k = 0; k < 3; k++) hi3[k] += int'(servo_out3[k]);
            end
        end
    end

    task automatic push_exp(input int fid, input int a0, input int a1, input int a2,
                            input int a3, input int b0, input int b1, input int b2);
        exp_t e;
        e.fid = fid;
        e.w[0] = a0; e.w[1] = a1; e.w[2] = a2; e.w[3] = a3;
        e.w3[0] = b0; e.w3[1] = b1; e.w3[2] = b2;
        sb_q.push_back(e);
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 3000);
        checks++;
        if (!frame_start) begin
            errors++;
            $display("FAIL wait_frame_start: got none after %0d clocks, expected one within %0d", n, FRAME);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (servo_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_servo_out: got %h expected 0", servo_out);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        ch_en = 4'hF;
        ch_en3 = 3'h7;
        repeat (5) @(negedge clk);
        checks++;
        if (servo_out !== 4'h0 || servo_out3 !== 3'h0) begin
            errors++;
            $display("FAIL reset_hold_outputs: got %h/%h expected 0/0", servo_out, servo_out3);
        end
        push_exp(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 3000);
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL first_frame_start: got %0d clocks expected %0d", n, FRAME);
        end
        $display("reset released, first frame_start after %0d clocks", n);
    endtask

    task automatic test_idle();
        int f = frame_idx;
        push_exp(f, 256, 256, 256, 256, 256, 256, 256);
        push_exp(f + 1, 256, 256, 256, 256, 256, 256, 256);
        wait_fs();
        wait_fs();
    endtask

    task automatic test_write_one();
        int f = frame_idx;
        push_exp(f, 256, 256, 256, 256, 256, 256, 256);
        push_exp(f + 1, 256, 356, 256, 256, 256, 256, 256);
        repeat (1000) @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'd1; wr_pos = 8'd100;
        @(negedge clk);
        wr_en = 1'b0;
        wait_fs();
        wait_fs();
    endtask

    task automatic test_last_wins();
        int f = frame_idx;
        int c = 0;
        push_exp(f, 256, 356, 256, 256, 256, 256, 256);
        push_exp(f + 1, 256, 356, 266, 256, 256, 256, 256);
        push_exp(f + 2, 256, 356, 266, 306, 256, 256, 256);
        while (c < 10) begin @(negedge clk); c++; end
        wr_en = 1'b1; wr_ch = 2'd2; wr_pos = 8'd255;
        @(negedge clk); c++;
        wr_en = 1'b0;
        while (c < 20) begin @(negedge clk); c++; end
        wr_en = 1'b1; wr_ch = 2'd2; wr_pos = 8'd10;
        @(negedge clk); c++;
        wr_en = 1'b0;
        while (c < FRAME - 1) begin @(negedge clk); c++; end
        wr_en = 1'b1; wr_ch = 2'd3; wr_pos = 8'd50;
        @(negedge clk); c++;
        wr_en = 1'b0;
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wrap_write_alignment: got frame_start=%b expected 1", frame_start);
        end
        wait_fs();
        wait_fs();
    endtask

    task automatic test_enable();
        int f = frame_idx;
        int c = 0;
        bit seen_hi = 1'b0;
        push_exp(f, 100, 356, 266, 306, 256, 256, 256);
        push_exp(f + 1, 256, 356, 266, 306, 276, 256, 256);
        while (c < 100) begin @(negedge clk); c++; end
        checks++;
        if (servo_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL ch0_high_before_drop: got %b expected 1", servo_out[0]);
        end
        ch_en[0] = 1'b0;
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_pos3 = 8'd200;
        @(negedge clk); c++;
        checks++;
        if (servo_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL ch0_low_after_drop: got %b expected 0", servo_out[0]);
        end
        wr_ch3 = 2'd0; wr_pos3 = 8'd20;
        @(negedge clk); c++;
        wr_en3 = 1'b0;
        do begin
            if (c == 150) ch_en[0] = 1'b1;
            if (servo_out[0]) seen_hi = 1'b1;
            @(negedge clk); c++;
        end while (!frame_start && c < 3000);
        checks++;
        if (seen_hi !== 1'b0) begin
            errors++;
            $display("FAIL ch0_no_runt: got high after re-enable expected low until frame_start");
        end
        wait_fs();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int c = 0;
        int first [4];
        int off;
        logic [3:0] exp_hi;
        logic [2:0] exp_hi3;
`ifdef SERVO_STAGGER_EN
        exp_hi = 4'h1; exp_hi3 = 3'h1;
`else
        exp_hi = 4'hF; exp_hi3 = 3'h7;
`endif
        repeat (50) @(negedge clk);
        checks++;
        if (servo_out !== exp_hi || servo_out3 !== exp_hi3) begin
            errors++;
            $display("FAIL mid_pulse_state: got %h/%h expected %h/%h", servo_out, servo_out3, exp_hi, exp_hi3);
        end
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (servo_out !== 4'h0 || servo_out3 !== 3'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h/%h expected 0/0", servo_out, servo_out3);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_frame_start: got %b expected 0", frame_start);
        end
        clk_run = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(0, 0, 0, 0, 0, 0, 0, 0);
        push_exp(1, 256, 256, 256, 256, 256, 256, 256);
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 3000);
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL rereset_first_frame_start: got %0d clocks expected %0d", n, FRAME);
        end
        for (int k = 0; k < 4; k++) first[k] = -1;
        do begin
            @(negedge clk); c++;
            for (int k = 0; k < 4; k++)
                if (servo_out[k] && first[k] < 0) first[k] = c;
        end while (!frame_start && c < 3000);
        for (int k = 0; k < 4; k++) begin
`ifdef SERVO_STAGGER_EN
            off = k * (FRAME / 4);
`else
            off = 0;
`endif
            checks++;
            if (first[k] != off + 1) begin
                errors++;
                $display("FAIL rise_ch%0d: got clock %0d expected %0d", k, first[k], off + 1);
            end
            $display("ch%0d rises at frame_cnt %0d", k, first[k] - 1);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_one();
        test_last_wins();
        test_enable();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter CH_COUNT, default 4: number of servo channels, 1..8.
REQ-002 Parameter POS_W, default 8: width of the position word.
REQ-003 Parameter CLK_DIV, default 0: a tick occurs every CLK_DIV+1 clocks.
REQ-004 Parameter FRAME_TICKS, default 2560: frame length in ticks.
REQ-005 Parameter BASE_TICKS, default 256: pulse width in ticks for position 0.
REQ-006 clk  input  1: single clock, all state on rising edge.
REQ-007 rst_n  input  1: reset, asynchronous, active-low.
REQ-008 wr_en  input  1: position write strobe, one write per asserted clock.
REQ-009 wr_ch  input  max(1,$clog2(CH_COUNT)): target channel index.
REQ-010 wr_pos  input  POS_W: new position value.
REQ-011 ch_en  input  CH_COUNT: per-channel output enable.
REQ-012 servo_out  output  CH_COUNT: registered pulse outputs.
REQ-013 frame_start  output  1: one-clock pulse at each frame boundary.

Function
REQ-014 Prescaler shall assert tick for one clock every CLK_DIV+1 clocks; with CLK_DIV=0, tick is permanently high.
REQ-015 frame_cnt shall increment on tick and wrap from FRAME_TICKS-1 to 0.
REQ-016 Wrap edge shall pulse frame_start for one clock, copy all shadow positions to active positions, and latch ch_en into en_act.
REQ-017 Width for channel k shall be BASE_TICKS + active_pos[k], computed at width POS_W+$clog2(FRAME_TICKS)+1 with no overflow.
REQ-018 Channel offset off_k shall be 0 (see REQ-028).
REQ-019 servo_out[k] shall be registered as en_act[k] & ch_en[k] & (frame_cnt - off_k < width_k, unsigned, frame_cnt >= off_k); output lags frame_cnt by one clock.
REQ-020 A write with wr_en=1 and wr_ch < CH_COUNT shall update shadow_pos[wr_ch] only; a write with wr_ch >= CH_COUNT shall be ignored.
REQ-021 Multiple writes to one channel within a frame: the last write wins.
REQ-022 A write on the same edge as the wrap shall land in shadow only and take effect in the following frame; the active copy uses the pre-write shadow.
REQ-023 Deasserting ch_en[k] shall drive servo_out[k] low on the next clock.
REQ-024 Reasserting ch_en[k] shall take effect only from the next frame start, which prevents runt pulses.

Reset
REQ-025 While rst_n=0, without a clock: servo_out=0, frame_start=0, prescaler=0, frame_cnt=0, shadow_pos=0, active_pos=0, en_act=0.
REQ-026 After release, first frame_start shall occur on the first wrap; no output pulses occur before it.
REQ-027 Reset asserted mid-pulse shall force outputs low immediately, and all pending shadow writes shall be discarded.

Configuration
REQ-028 With SERVO_STAGGER_EN defined: off_k = k*(FRAME_TICKS/CH_COUNT), so channel rising edges never coincide.
REQ-029 With SERVO_STAGGER_EN undefined: off_k=0 for all k, and no offset logic is generated.
REQ-030 With SERVO_STAGGER_EN defined, BASE_TICKS + 2^POS_W - 1 <= FRAME_TICKS/CH_COUNT shall hold; elaboration shall fail otherwise.

Structure
REQ-031 Package servo_pkg shall hold default parameter constants, the channel-index width function and the width-of-pulse constant expression.
REQ-032 Sub-module servo_prescaler (clk, rst_n, tick) shall implement REQ-014 and shall be reusable for the SPI and timer dividers.

Verification
Configuration for all scenarios: CH_COUNT=4, POS_W=8, CLK_DIV=0, FRAME_TICKS=2560, BASE_TICKS=256, unless stated otherwise.
REQ-033 Reset, then ch_en=4'hF, no writes -> from the second frame each servo_out high for exactly 256 clocks per 2560-clock frame; frame_start period is 2560.
REQ-034 Write ch1 pos=100 at frame_cnt=1000 -> current frame ch1 high 256 clocks, next frame 356 clocks; other channels unchanged.
REQ-035 Write ch2 pos=255 then pos=10 in one frame, plus a write ch3 pos=50 on the frame_start edge -> next frame ch2 high 266 clocks and ch3 high 256 clocks; the frame after, ch3 high 306 clocks.
REQ-036 Drop ch_en[0] at clock 100 of a pulse -> servo_out[0] low next clock; reassert at clock 150 -> stays low until the next frame, then 256-clock pulse. Also: CH_COUNT=3, write wr_ch=3 -> no state change.
REQ-037 Assert rst_n=0 mid-pulse with clk stopped -> all outputs 0 within the same timestep. SERVO_STAGGER_EN defined -> ch0..ch3 rise at frame_cnt 0, 640, 1280 and 1920.
